// File: rtl/iob_eth_tx_sched.sv
// Round-robin scheduler that shares one Ethernet TX engine between N_REQ frame sources.
// Optional macro ETH_TX_IFG_EN adds a 24-cycle inter-frame gap after every acknowledged frame.
module iob_eth_tx_sched #(
    parameter int N_REQ   = 2,
    parameter int SEND_W  = 4,
    parameter int TO_W    = 16,
    parameter int MAX_LEN = 1500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [11*N_REQ-1:0]  nbytes_in,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     err,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 tx_send,
    output logic [10:0]          tx_nbytes,
    input  logic                 tx_ready
);

    localparam int              PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int              SCW       = (SEND_W > 1) ? $clog2(SEND_W) : 1;
    localparam logic [10:0]     MAX_LEN_W = 11'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_MAX    = {TO_W{1'b1}};
    localparam logic [PW-1:0]   LAST_IDX  = PW'(N_REQ - 1);
    localparam logic [SCW-1:0]  SEND_LAST = SCW'(SEND_W - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] REJ       = 3'd4;
`ifdef ETH_TX_IFG_EN
    localparam logic [2:0] IFG       = 3'd5;
    localparam logic [4:0] IFG_LAST  = 5'd23;
`endif

    logic [2:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gidx;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    pick_idx;
    logic             pick_vld;
    logic [N_REQ-1:0] pick_oh;
    logic [10:0]      pick_len;
    logic             len_bad;
    logic             arb_slot;
    logic             rdy_m;
    logic             rdy_s;
    logic [SCW-1:0]   send_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_nxt;
    logic             to_hit;
`ifdef ETH_TX_IFG_EN
    logic [4:0]       ifg_cnt;
`endif

    // Scan offsets from farthest to nearest so the last hit is the first set bit at/after ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = PW'((int'(ptr) + off) % N_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    assign pick_len = nbytes_in[11*int'(pick_idx) +: 11];
    assign len_bad  = (pick_len == 11'd0) || (pick_len > MAX_LEN_W);
    assign ptr_nxt  = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
    assign to_nxt   = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;
    assign to_hit   = (to_nxt == TO_MAX);
    assign busy     = (state != IDLE);

`ifdef ETH_TX_IFG_EN
    // The last gap cycle arbitrates so that exactly 24 cycles separate ack from the next grant.
    assign arb_slot = (state == IDLE) || ((state == IFG) && (ifg_cnt == IFG_LAST));
`else
    assign arb_slot = (state == IDLE);
`endif

    // tx_ready comes from the TX_CLK domain; idle engine reads as ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_m <= 1'b1;
            rdy_s <= 1'b1;
        end else begin
            rdy_m <= tx_ready;
            rdy_s <= rdy_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            grant     <= '0;
            ack       <= '0;
            err       <= '0;
            tx_send   <= 1'b0;
            tx_nbytes <= '0;
            send_cnt  <= '0;
            to_cnt    <= '0;
`ifdef ETH_TX_IFG_EN
            ifg_cnt   <= '0;
`endif
        end else begin
            // NOTE: ack/err default low every cycle, so any set below is a single-cycle pulse.
            ack <= '0;
            err <= '0;
            if (arb_slot) begin
                if (pick_vld) begin
                    grant     <= pick_oh;
                    gidx      <= pick_idx;
                    tx_nbytes <= pick_len;
                    if (len_bad) begin
                        state <= REJ;
                    end else begin
                        state    <= SEND;
                        tx_send  <= 1'b1;
                        send_cnt <= '0;
                    end
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    SEND: begin
                        if (send_cnt == SEND_LAST) begin
                            tx_send <= 1'b0;
                            to_cnt  <= '0;
                            state   <= WAIT_BUSY;
                        end else begin
                            send_cnt <= send_cnt + 1'b1;
                        end
                    end
                    WAIT_BUSY: begin
                        if (!rdy_s) begin
                            to_cnt <= '0;
                            state  <= WAIT_DONE;
                        end else if (to_hit) begin
                            err   <= grant;
                            grant <= '0;
                            ptr   <= ptr_nxt;
                            state <= IDLE;
                        end else begin
                            to_cnt <= to_nxt;
                        end
                    end
                    WAIT_DONE: begin
                        if (rdy_s) begin
                            ack   <= grant;
                            grant <= '0;
                            ptr   <= ptr_nxt;
`ifdef ETH_TX_IFG_EN
                            ifg_cnt <= '0;
                            state   <= IFG;
`else
                            state   <= IDLE;
`endif
                        end else if (to_hit) begin
                            err   <= grant;
                            grant <= '0;
                            ptr   <= ptr_nxt;
                            state <= IDLE;
                        end else begin
                            to_cnt <= to_nxt;
                        end
                    end
                    REJ: begin
                        err   <= grant;
                        grant <= '0;
                        ptr   <= ptr_nxt;
                        state <= IDLE;
                    end
`ifdef ETH_TX_IFG_EN
                    IFG: begin
                        ifg_cnt <= ifg_cnt + 1'b1;
                    end
`endif
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iob_eth_tx_sched.sv
// Directed self-checking bench for iob_eth_tx_sched: a default instance with a TX engine model,
// plus a TO_W=4 instance whose engine stays ready to exercise the timeout path.
module tb_iob_eth_tx_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [21:0] nbytes_in;
    logic [1:0]  ack, err, grant;
    logic        busy, tx_send;
    logic [10:0] tx_nbytes;
    logic        tx_ready;

    logic [1:0]  t_req;
    logic [21:0] t_nbytes;
    logic [1:0]  t_ack, t_err, t_grant;
    logic        t_busy, t_send;
    logic [10:0] t_nbytes_o;
    logic        t_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int eng_low = 20;

`ifdef ETH_TX_IFG_EN
    localparam int   EXP_GAP      = 24;
    localparam logic EXP_ACK_BUSY = 1'b1;
`else
    localparam int   EXP_GAP      = 1;
    localparam logic EXP_ACK_BUSY = 1'b0;
`endif

    iob_eth_tx_sched dut (
        .clk(clk), .rst(rst), .req(req), .nbytes_in(nbytes_in),
        .ack(ack), .err(err), .grant(grant), .busy(busy),
        .tx_send(tx_send), .tx_nbytes(tx_nbytes), .tx_ready(tx_ready)
    );

    iob_eth_tx_sched #(.TO_W(4)) dut_to (
        .clk(clk), .rst(rst), .req(t_req), .nbytes_in(t_nbytes),
        .ack(t_ack), .err(t_err), .grant(t_grant), .busy(t_busy),
        .tx_send(t_send), .tx_nbytes(t_nbytes_o), .tx_ready(t_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: ready drops 3 cycles after a send strobe and returns eng_low cycles later.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge tx_send);
            repeat (3) @(posedge clk);
            #1 tx_ready = 1'b0;
            repeat (eng_low) @(posedge clk);
            #1 tx_ready = 1'b1;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req   = 2'b00;
        t_req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (ack !== 2'b00)        begin n_bad++; $display("FAIL rst_ack: got %b want 00", ack); end
        n_cmp++; if (err !== 2'b00)        begin n_bad++; $display("FAIL rst_err: got %b want 00", err); end
        n_cmp++; if (grant !== 2'b00)      begin n_bad++; $display("FAIL rst_grant: got %b want 00", grant); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (tx_send !== 1'b0)     begin n_bad++; $display("FAIL rst_tx_send: got %b want 0", tx_send); end
        n_cmp++; if (tx_nbytes !== 11'd0)  begin n_bad++; $display("FAIL rst_tx_nbytes: got %0d want 0", tx_nbytes); end
        n_cmp++; if (t_grant !== 2'b00)    begin n_bad++; $display("FAIL rst_t_grant: got %b want 00", t_grant); end
        n_cmp++; if (t_busy !== 1'b0)      begin n_bad++; $display("FAIL rst_t_busy: got %b want 0", t_busy); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        eng_low = 200;
        nbytes_in[10:0] = 11'd64;
        req = 2'b01;
        @(negedge clk);
        n_cmp++; if (grant !== 2'b01)      begin n_bad++; $display("FAIL t1_grant: got %b want 01", grant); end
        n_cmp++; if (tx_send !== 1'b1)     begin n_bad++; $display("FAIL t1_send_rise: got %b want 1", tx_send); end
        n_cmp++; if (tx_nbytes !== 11'd64) begin n_bad++; $display("FAIL t1_nbytes: got %0d want 64", tx_nbytes); end
        n_cmp++; if (busy !== 1'b1)        begin n_bad++; $display("FAIL t1_busy: got %b want 1", busy); end
        n = 0;
        while (tx_send === 1'b1 && n < 20) begin n++; @(negedge clk); end
        n_cmp++; if (n != 4)               begin n_bad++; $display("FAIL t1_send_width: got %0d want 4", n); end
        n = 0;
        while (ack === 2'b00 && err === 2'b00 && n < 400) begin n++; @(negedge clk); end
        req = 2'b00;
        n_cmp++; if (ack !== 2'b01)        begin n_bad++; $display("FAIL t1_ack: got %b want 01", ack); end
        n_cmp++; if (err !== 2'b00)        begin n_bad++; $display("FAIL t1_err: got %b want 00", err); end
        n_cmp++; if (grant !== 2'b00)      begin n_bad++; $display("FAIL t1_grant_clr: got %b want 00", grant); end
        @(negedge clk);
        n_cmp++; if (ack !== 2'b00)        begin n_bad++; $display("FAIL t1_ack_pulse: got %b want 00", ack); end
        repeat (30) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL t1_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        int n;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        eng_low = 20;
        nbytes_in = {11'd100, 11'd100};
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (grant === 2'b00 && n < 50) begin n++; @(negedge clk); end
            n_cmp++; if (grant !== exp_g[i])   begin n_bad++; $display("FAIL t2_grant%0d: got %b want %b", i, grant, exp_g[i]); end
            n_cmp++; if (tx_nbytes !== 11'd100) begin n_bad++; $display("FAIL t2_nbytes%0d: got %0d want 100", i, tx_nbytes); end
            n = 0;
            while (ack === 2'b00 && err === 2'b00 && n < 200) begin n++; @(negedge clk); end
            n_cmp++; if (ack !== exp_g[i])     begin n_bad++; $display("FAIL t2_ack%0d: got %b want %b", i, ack, exp_g[i]); end
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reject();
        logic [10:0] bad_len [2];
        bad_len = '{11'd0, 11'd1501};
        do_reset();
        eng_low = 20;
        for (int i = 0; i < 2; i++) begin
            nbytes_in[21:11] = bad_len[i];
            req = 2'b10;
            @(negedge clk);
            n_cmp++; if (grant !== 2'b10)   begin n_bad++; $display("FAIL t3_grant%0d: got %b want 10", i, grant); end
            n_cmp++; if (tx_send !== 1'b0)  begin n_bad++; $display("FAIL t3_send%0d: got %b want 0", i, tx_send); end
            @(negedge clk);
            req = 2'b00;
            n_cmp++; if (err !== 2'b10)     begin n_bad++; $display("FAIL t3_err%0d: got %b want 10", i, err); end
            n_cmp++; if (ack !== 2'b00)     begin n_bad++; $display("FAIL t3_ack%0d: got %b want 00", i, ack); end
            n_cmp++; if (tx_send !== 1'b0)  begin n_bad++; $display("FAIL t3_send_late%0d: got %b want 0", i, tx_send); end
            @(negedge clk);
            n_cmp++; if (err !== 2'b00)     begin n_bad++; $display("FAIL t3_err_pulse%0d: got %b want 00", i, err); end
        end
        nbytes_in[21:11] = 11'd1500;
        req = 2'b10;
        @(negedge clk);
        n_cmp++; if (tx_send !== 1'b1)      begin n_bad++; $display("FAIL t3_max_len_send: got %b want 1", tx_send); end
        do_reset();
        repeat (30) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        t_nbytes[10:0] = 11'd64;
        t_req = 2'b01;
        @(negedge clk);
        n_cmp++; if (t_grant !== 2'b01)     begin n_bad++; $display("FAIL t4_grant: got %b want 01", t_grant); end
        n = 0;
        while (t_send === 1'b1 && n < 20) begin n++; @(negedge clk); end
        n_cmp++; if (n != 4)                begin n_bad++; $display("FAIL t4_send_width: got %0d want 4", n); end
        repeat (14) @(negedge clk);
        n_cmp++; if (t_err !== 2'b00)       begin n_bad++; $display("FAIL t4_err_early: got %b want 00", t_err); end
        n_cmp++; if (t_busy !== 1'b1)       begin n_bad++; $display("FAIL t4_busy_wait: got %b want 1", t_busy); end
        @(negedge clk);
        t_req = 2'b00;
        n_cmp++; if (t_err !== 2'b01)       begin n_bad++; $display("FAIL t4_err: got %b want 01", t_err); end
        n_cmp++; if (t_ack !== 2'b00)       begin n_bad++; $display("FAIL t4_ack: got %b want 00", t_ack); end
        n_cmp++; if (t_grant !== 2'b00)     begin n_bad++; $display("FAIL t4_grant_clr: got %b want 00", t_grant); end
        n_cmp++; if (t_busy !== 1'b0)       begin n_bad++; $display("FAIL t4_idle: got %b want 0", t_busy); end
        @(negedge clk);
        t_nbytes[21:11] = 11'd64;
        t_req = 2'b11;
        @(negedge clk);
        n_cmp++; if (t_grant !== 2'b10)     begin n_bad++; $display("FAIL t4_ptr_moved: got %b want 10", t_grant); end
        t_req = 2'b00;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        do_reset();
        eng_low = 200;
        nbytes_in[21:11] = 11'd64;
        req = 2'b10;
        @(negedge clk);
        n_cmp++; if (grant !== 2'b10)       begin n_bad++; $display("FAIL t5_grant: got %b want 10", grant); end
        n = 0;
        while (tx_ready === 1'b1 && n < 20) begin n++; @(negedge clk); end
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (grant !== 2'b00)       begin n_bad++; $display("FAIL t5_async_grant: got %b want 00", grant); end
        n_cmp++; if (tx_send !== 1'b0)      begin n_bad++; $display("FAIL t5_async_send: got %b want 0", tx_send); end
        n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL t5_async_busy: got %b want 0", busy); end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ((ack | err) !== 2'b00) begin n_bad++; $display("FAIL t5_no_pulse%0d: got ack=%b err=%b want 00", i, ack, err); end
        end
        n = 0;
        while (tx_ready === 1'b0 && n < 300) begin n++; @(negedge clk); end
        eng_low = 20;
        req = 2'b10;
        @(negedge clk);
        n_cmp++; if (grant !== 2'b10)       begin n_bad++; $display("FAIL t5_regrant: got %b want 10", grant); end
        do_reset();
        repeat (30) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        int gap;
        do_reset();
        eng_low = 20;
        nbytes_in = {11'd100, 11'd100};
        req = 2'b11;
        n = 0;
        while (grant === 2'b00 && n < 50) begin n++; @(negedge clk); end
        n_cmp++; if (grant !== 2'b01)       begin n_bad++; $display("FAIL t6_grant0: got %b want 01", grant); end
        n = 0;
        while (ack === 2'b00 && err === 2'b00 && n < 200) begin n++; @(negedge clk); end
        n_cmp++; if (ack !== 2'b01)         begin n_bad++; $display("FAIL t6_ack0: got %b want 01", ack); end
        n_cmp++; if (busy !== EXP_ACK_BUSY) begin n_bad++; $display("FAIL t6_busy_at_ack: got %b want %b", busy, EXP_ACK_BUSY); end
        gap = 0;
        while (grant === 2'b00 && gap < 100) begin gap++; @(negedge clk); end
        n_cmp++; if (gap != EXP_GAP)        begin n_bad++; $display("FAIL t6_gap: got %0d want %0d", gap, EXP_GAP); end
        n_cmp++; if (grant !== 2'b10)       begin n_bad++; $display("FAIL t6_grant1: got %b want 10", grant); end
        n = 0;
        while (ack === 2'b00 && err === 2'b00 && n < 200) begin n++; @(negedge clk); end
        req = 2'b00;
        n_cmp++; if (ack !== 2'b10)         begin n_bad++; $display("FAIL t6_ack1: got %b want 10", ack); end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 2'b00;
        nbytes_in = '0;
        t_req     = 2'b00;
        t_nbytes  = '0;
        t_ready   = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_reject();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
